scan_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the scan chain controller between up to NUM_REQ requesters, e.g. Caravel firmware, a debug UART and a self-test engine. Each request carries a design index and one input byte. The block runs exactly one complete refresh pass of the scan controller for that request and returns the design's output byte. It sits upstream of scan_controller and drives that block's active_select, inputs and internal-driver enable, and observes its ready and outputs.

---
 rtl/scan_arb_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 28 ++
 rtl/scan_arbiter.sv | 166 ++++++++++++++++
 tb/tb_scan_arbiter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/scan_arb_pkg.sv
// Shared types and default sizes for the scan chain arbiter.
package scan_arb_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_WAIT_START,
        S_WAIT_DONE,
        S_RESP
    } state_t;

    localparam int DEF_NUM_IOS   = 8;
    localparam int DEF_SEL_W     = 9;
    localparam int DEF_SETUP_CYC = 3;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first request above last_grant, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic               any
);

    always_comb begin
        int pos;
        grant = '0;
        any   = 1'b0;
        pos   = 0;
        // k = NUM_REQ revisits last_grant itself, so a lone requester can win again
        for (int k = 1; k <= NUM_REQ; k++) begin
            pos = int'(last_grant) + k;
            if (pos >= NUM_REQ) pos = pos - NUM_REQ;
            if (!any && req[pos[IDX_W-1:0]]) begin
                grant[pos[IDX_W-1:0]] = 1'b1;
                any                   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/scan_arbiter.sv
// Shares one scan controller among NUM_REQ requesters, one full refresh pass per request.
// Optional abort counter enabled by defining SCAN_ARB_TIMEOUT_EN.
module scan_arbiter
    import scan_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int NUM_IOS   = DEF_NUM_IOS,
    parameter int SEL_W     = DEF_SEL_W,
    parameter int SETUP_CYC = DEF_SETUP_CYC,
    parameter int TIMEOUT   = 4095
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*SEL_W-1:0]   req_sel,
    input  logic [NUM_REQ*NUM_IOS-1:0] req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [NUM_REQ-1:0]         rsp_valid,
    output logic [NUM_IOS-1:0]         rsp_data,
    output logic                       rsp_timeout,
    output logic                       ctl_run,
    output logic [SEL_W-1:0]           ctl_active_select,
    output logic [NUM_IOS-1:0]         ctl_inputs,
    input  logic                       ctl_ready,
    input  logic [NUM_IOS-1:0]         ctl_outputs
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int SU_W  = $clog2(SETUP_CYC + 1);

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     last_grant_q, last_grant_d;
    logic [SU_W-1:0]      su_cnt_q, su_cnt_d;
    logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [NUM_IOS-1:0]   rsp_data_q, rsp_data_d;
    logic                 ctl_run_q, ctl_run_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic [NUM_IOS-1:0]   inputs_q, inputs_d;

    logic [NUM_REQ-1:0]   grant;
    logic                 grant_any;
    logic [IDX_W-1:0]     win_idx;

`ifdef SCAN_ARB_TIMEOUT_EN
    logic [11:0]          tmo_q, tmo_d;
    logic                 rsp_timeout_q, rsp_timeout_d;
`endif

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .grant      (grant),
        .any        (grant_any)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) win_idx = IDX_W'(i);
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        su_cnt_d     = su_cnt_q;
        rsp_valid_d  = '0;
        rsp_data_d   = rsp_data_q;
        sel_d        = sel_q;
        inputs_d     = inputs_q;
`ifdef SCAN_ARB_TIMEOUT_EN
        tmo_d         = tmo_q;
        rsp_timeout_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (grant_any) begin
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (grant[i]) begin
                            sel_d    = req_sel[i*SEL_W +: SEL_W];
                            inputs_d = req_data[i*NUM_IOS +: NUM_IOS];
                        end
                    end
                    last_grant_d = win_idx;
                    su_cnt_d     = '0;
                    state_d      = S_SETUP;
`ifdef SCAN_ARB_TIMEOUT_EN
                    tmo_d = '0;
`endif
                end
            end
            // Give the controller's input synchronizer time before trusting ready
            S_SETUP: begin
                if (su_cnt_q == SU_W'(SETUP_CYC - 1)) state_d = S_WAIT_START;
                else su_cnt_d = su_cnt_q + 1'b1;
            end
            S_WAIT_START: begin
                if (ctl_ready) state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (ctl_ready) begin
                    rsp_data_d  = ctl_outputs;
                    rsp_valid_d = NUM_REQ'(1) << last_grant_q;
                    state_d     = S_RESP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
`ifdef SCAN_ARB_TIMEOUT_EN
        if (state_q == S_SETUP || state_q == S_WAIT_START || state_q == S_WAIT_DONE) begin
            tmo_d = tmo_q + 1'b1;
            if (tmo_q == 12'(TIMEOUT - 1) && state_d != S_RESP) begin
                state_d       = S_RESP;
                rsp_valid_d   = NUM_REQ'(1) << last_grant_q;
                rsp_data_d    = '0;
                rsp_timeout_d = 1'b1;
            end
        end
`endif
        ctl_run_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            su_cnt_q     <= '0;
            rsp_valid_q  <= '0;
            rsp_data_q   <= '0;
            ctl_run_q    <= 1'b0;
            sel_q        <= '0;
            inputs_q     <= '0;
`ifdef SCAN_ARB_TIMEOUT_EN
            tmo_q         <= '0;
            rsp_timeout_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            su_cnt_q     <= su_cnt_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            ctl_run_q    <= ctl_run_d;
            sel_q        <= sel_d;
            inputs_q     <= inputs_d;
`ifdef SCAN_ARB_TIMEOUT_EN
            tmo_q         <= tmo_d;
            rsp_timeout_q <= rsp_timeout_d;
`endif
        end
    end

    assign req_ready         = (state_q == S_IDLE && !reset) ? grant : '0;
    assign rsp_valid         = rsp_valid_q;
    assign rsp_data          = rsp_data_q;
    assign ctl_run           = ctl_run_q;
    assign ctl_active_select = sel_q;
    assign ctl_inputs        = inputs_q;
`ifdef SCAN_ARB_TIMEOUT_EN
    assign rsp_timeout = rsp_timeout_q;
`else
    assign rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_scan_arbiter.sv
// Directed, table-driven bench for scan_arbiter with a hand-driven controller.
module tb_scan_arbiter;

    localparam int SETUP_CYC = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [35:0] req_sel;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic [3:0]  rsp_valid;
    logic [7:0]  rsp_data;
    logic        rsp_timeout;
    logic        ctl_run;
    logic [8:0]  ctl_active_select;
    logic [7:0]  ctl_inputs;
    logic        ctl_ready;
    logic [7:0]  ctl_outputs;

    int checks = 0;
    int errors = 0;
    logic [7:0] last_cout;

    scan_arbiter #(
        .NUM_REQ(4), .NUM_IOS(8), .SEL_W(9), .SETUP_CYC(SETUP_CYC), .TIMEOUT(20)
    ) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_sel(req_sel),
        .req_data(req_data), .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_data(rsp_data), .rsp_timeout(rsp_timeout), .ctl_run(ctl_run),
        .ctl_active_select(ctl_active_select), .ctl_inputs(ctl_inputs),
        .ctl_ready(ctl_ready), .ctl_outputs(ctl_outputs)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] mask;
        logic [3:0] pend;
        logic [3:0] rereq;
        logic [8:0] sel;
        logic [7:0] din;
        logic [7:0] cout;
        int         exp;
        bit         glitch;
        bit         abort;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, req);
        end
    endtask

    task automatic do_txn(input vec_t v);
        logic [8:0] es;
        logic [7:0] ed;
        logic [3:0] eg;
        int n;
        es = v.sel + 9'(v.exp);
        ed = v.din ^ 8'(v.exp);
        eg = 4'b0001 << v.exp;
        @(negedge clk);
        req_valid = v.mask;
        for (int i = 0; i < 4; i++) begin
            req_sel[i*9 +: 9]  = v.sel + 9'(i);
            req_data[i*8 +: 8] = v.din ^ 8'(i);
        end
        #1;
        chk("idle_run", 32'(ctl_run), 0);
        chk("rsp_idle", 32'(rsp_valid), 0);
        chk("rsp_hold", 32'(rsp_data), 32'(last_cout));
        n = 0;
        while (req_ready == 4'b0 && n < 8) begin
            @(negedge clk); #1; n++;
        end
        chk("grant_gap", n, 0);
        chk("req_ready", 32'(req_ready), 32'(eg));
        @(negedge clk);
        req_valid = v.pend;
        #1;
        chk("run_on", 32'(ctl_run), 1);
        chk("sel", 32'(ctl_active_select), 32'(es));
        chk("inputs", 32'(ctl_inputs), 32'(ed));
        chk("ready_low", 32'(req_ready), 0);
        if (v.glitch) ctl_ready = 1'b1;
        @(negedge clk);
        ctl_ready = 1'b0;
        repeat (SETUP_CYC - 1) @(negedge clk);
        ctl_ready = 1'b1;
        @(negedge clk);
        ctl_ready = 1'b0;
        #1;
        chk("no_early_rsp", 32'(rsp_valid), 0);
        if (v.abort) begin
            reset       = 1'b1;
            ctl_ready   = 1'b1;
            ctl_outputs = 8'hEE;
            @(negedge clk);
            ctl_ready = 1'b0;
            #1;
            chk("rst_rsp_valid", 32'(rsp_valid), 0);
            chk("rst_run", 32'(ctl_run), 0);
            chk("rst_sel", 32'(ctl_active_select), 0);
            chk("rst_inputs", 32'(ctl_inputs), 0);
            chk("rst_data", 32'(rsp_data), 0);
            chk("rst_ready", 32'(req_ready), 0);
            reset     = 1'b0;
            last_cout = 8'h00;
        end else begin
            @(negedge clk);
            #1;
            chk("wait_done_rsp", 32'(rsp_valid), 0);
            ctl_ready   = 1'b1;
            ctl_outputs = v.cout;
            @(negedge clk);
            ctl_ready = 1'b0;
            #1;
            chk("rsp_valid", 32'(rsp_valid), 32'(eg));
            chk("rsp_data", 32'(rsp_data), 32'(v.cout));
            chk("rsp_timeout", 32'(rsp_timeout), 0);
            chk("resp_run", 32'(ctl_run), 1);
            chk("resp_sel", 32'(ctl_active_select), 32'(es));
            req_valid = v.pend | v.rereq;
            last_cout = v.cout;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //            mask     pend     rereq    sel     din    cout   exp gl ab
        vecs[0]  = '{4'b0001, 4'b0000, 4'b0000, 9'd5,   8'hA5, 8'h3C, 0, 0, 0};
        vecs[1]  = '{4'b1111, 4'b0000, 4'b0000, 9'd10,  8'h0F, 8'hC3, 1, 1, 0};
        vecs[2]  = '{4'b1111, 4'b0000, 4'b0000, 9'd20,  8'h5A, 8'h81, 2, 0, 0};
        vecs[3]  = '{4'b1111, 4'b0000, 4'b0000, 9'd30,  8'h11, 8'h7E, 3, 0, 0};
        vecs[4]  = '{4'b1111, 4'b0000, 4'b0000, 9'd40,  8'h22, 8'h01, 0, 0, 0};
        vecs[5]  = '{4'b0101, 4'b0000, 4'b0000, 9'd50,  8'h33, 8'h02, 2, 0, 0};
        vecs[6]  = '{4'b0101, 4'b0000, 4'b0000, 9'd60,  8'h44, 8'h04, 0, 0, 0};
        vecs[7]  = '{4'b1000, 4'b0000, 4'b0000, 9'd70,  8'h55, 8'h08, 3, 0, 0};
        vecs[8]  = '{4'b0011, 4'b0000, 4'b0000, 9'd80,  8'h66, 8'h10, 0, 1, 0};
        vecs[9]  = '{4'b0010, 4'b0000, 4'b0000, 9'h1FE, 8'hFF, 8'h00, 1, 0, 0};
        vecs[10] = '{4'b1100, 4'b1000, 4'b0100, 9'd100, 8'h77, 8'h20, 2, 0, 0};
        vecs[11] = '{4'b1100, 4'b0000, 4'b0000, 9'd110, 8'h88, 8'h40, 3, 0, 0};
        vecs[12] = '{4'b0100, 4'b0000, 4'b0000, 9'd120, 8'h99, 8'h80, 2, 0, 0};
        vecs[13] = '{4'b0010, 4'b0000, 4'b0000, 9'd130, 8'hAA, 8'hEE, 1, 0, 1};
        vecs[14] = '{4'b1111, 4'b0000, 4'b0000, 9'd140, 8'hBB, 8'h5F, 0, 0, 0};
        vecs[15] = '{4'b0001, 4'b0000, 4'b0000, 9'd150, 8'hCC, 8'hF5, 0, 0, 0};

        reset       = 1'b1;
        req_valid   = 4'b1111;
        req_sel     = '0;
        req_data    = '0;
        ctl_ready   = 1'b0;
        ctl_outputs = 8'h00;
        last_cout   = 8'h00;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_req_ready", 32'(req_ready), 0);
        chk("reset_rsp_valid", 32'(rsp_valid), 0);
        chk("reset_run", 32'(ctl_run), 0);
        chk("reset_sel", 32'(ctl_active_select), 0);
        chk("reset_inputs", 32'(ctl_inputs), 0);
        chk("reset_data", 32'(rsp_data), 0);
        chk("reset_timeout", 32'(rsp_timeout), 0);
        req_valid = 4'b0000;
        reset     = 1'b0;

        for (int t = 0; t < 16; t++) do_txn(vecs[t]);

`ifdef SCAN_ARB_TIMEOUT_EN
        begin
            int n;
            @(negedge clk);
            req_valid = 4'b0001;
            #1;
            chk("tmo_grant", 32'(req_ready), 32'h1);
            @(negedge clk);
            req_valid = 4'b0000;
            n = 1;
            #1;
            while (rsp_valid == 4'b0 && n < 40) begin
                @(negedge clk); #1; n++;
            end
            chk("tmo_latency_window", 32'(n >= 21 && n <= 22), 1);
            chk("tmo_rsp_valid", 32'(rsp_valid), 32'h1);
            chk("tmo_flag", 32'(rsp_timeout), 1);
            chk("tmo_data", 32'(rsp_data), 0);
        end
`endif

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
